sram_responder: RTL and testbench
=================================

SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning implemented word-address bits (internal array 2^ADDR_W x 16).
REQ-002 SHALL have parameter RD_LAT, default 2, range 1..6, meaning cycles from sampled read request to SRAM_DB_O/SRAM_DB_T valid.
REQ-003 SHALL have ports listed below; SRAM_sys_clk is the single clock; SRAM_rst_n is asynchronous, active-low.
REQ-004 SRAM_sys_clk  in  1  system clock, all logic on rising edge.
REQ-005 SRAM_rst_n  in  1  asynchronous active-low reset.
REQ-006 SRAM_A  in  18  word address from initiator.
REQ-007 SRAM_DB_I  in  16  data driven by initiator (pad buffer output).
REQ-008 SRAM_DB_O  out  16  read data toward pad buffer input.
REQ-009 SRAM_DB_T  out  1  pad tristate control, 1 = high-Z, 0 = drive SRAM_DB_O.
REQ-010 SRAM_CE_N, SRAM_WE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N  in  1 each  active-low chip, write, output, upper-byte, lower-byte enables.
REQ-011 wr_count  out  32  sampled write cycles since reset.
REQ-012 rd_count  out  32  distinct read words since reset.
REQ-013 bus_conflict  out  1  sticky: WE_N and OE_N sampled low together.

Function
REQ-014 SHALL register all bus inputs once (sample stage S) every cycle; all decisions use S-stage values only.
REQ-015 Decoded mode from S: IDLE if CE_N=1 or (WE_N=1 and OE_N=1); WRITE if CE_N=0 and WE_N=0; READ if CE_N=0, WE_N=1, OE_N=0.
REQ-016 WRITE SHALL commit S data to array[A[ADDR_W-1:0]] on the edge after sampling; [15:8] only if UB_N=0, [7:0] only if LB_N=0; one word per cycle while WE_N stays low.
REQ-017 Address bits above ADDR_W SHALL be ignored (aliasing); no error raised.
REQ-018 READ SHALL return array[A[ADDR_W-1:0]] on SRAM_DB_O exactly RD_LAT cycles after S-stage sampling, with SRAM_DB_T=0 in the same cycle; lanes with UB_N/LB_N=1 output 8'h00.
REQ-019 SRAM_DB_T SHALL be 1 in every cycle whose RD_LAT-delayed mode is not READ; SRAM_DB_O SHALL hold last value when SRAM_DB_T=1.
REQ-020 Write sampled at edge k followed by read of same address sampled at edge k+1 SHALL return the new data.
REQ-021 WE_N=0 and OE_N=0 sampled together: treat as WRITE, SRAM_DB_T=1, set bus_conflict until reset.
REQ-022 wr_count SHALL increment per WRITE-mode S cycle with at least one byte lane enabled; saturate at 32'hFFFFFFFF.
REQ-023 rd_count SHALL increment on a READ-mode S cycle when previous S cycle was not READ or its address differed; saturate at 32'hFFFFFFFF.
REQ-024 Mode change READ->WRITE SHALL float the bus (SRAM_DB_T=1) no later than the cycle the WRITE is sampled; delayed read data in flight is discarded.

Reset
REQ-025 On SRAM_rst_n=0: SRAM_DB_T=1, SRAM_DB_O=16'h0000, wr_count=0, rd_count=0, bus_conflict=0, S stage and read pipeline cleared to IDLE, immediately and asynchronously.
REQ-026 Array contents SHALL be unaffected by reset; reset mid-write drops only the uncommitted S-stage word.

Configuration
REQ-027 With macro SRAM_RSP_FAULT_EN defined: extra inputs fault_en (1) and fault_addr (18); when fault_en=1 and read address[ADDR_W-1:0] equals fault_addr[ADDR_W-1:0], read data bit 0 SHALL be inverted; array contents are unchanged.
REQ-028 Without SRAM_RSP_FAULT_EN: those ports absent; read data always equals stored data.

Verification
REQ-029 Reset, write 16'haa55 to A=0 and 16'h55aa to A=1 with UB_N=LB_N=0, then read each with OE_N=0 -> 16'haa55 and 16'h55aa exactly RD_LAT cycles after sampling, wr_count=2, rd_count=2.
REQ-030 Full 18-bit sweep writing alternating aa55/55aa, then reads holding each address 8 cycles -> all data match, rd_count=262144, wr_count=262144 (aliasing preserves the alternating pattern).
REQ-031 Write 16'hffff, then write 16'h1234 with UB_N=1 -> read returns 16'hff34; read with LB_N=1 -> 16'hff00.
REQ-032 WE_N=0 and OE_N=0 together for one cycle -> bus_conflict=1, SRAM_DB_T stays 1, cleared only by reset.
REQ-033 With SRAM_RSP_FAULT_EN, fault_en=1, fault_addr=5, stored 16'haa55 at 5 -> read returns 16'haa54; other addresses return stored data.
REQ-034 Assert reset during a read burst -> SRAM_DB_T=1 asynchronously, counters 0, previously written data still readable afterward.

Source files
------------

// File: rtl/sram_responder.sv
// Synchronous SRAM target model: registered bus sampling, byte-lane writes, RD_LAT read pipeline.
// Optional macro SRAM_RSP_FAULT_EN adds fault_en/fault_addr ports that flip read data bit 0 at one address.
module sram_responder #(
   parameter int ADDR_W = 10,
   parameter int RD_LAT = 2
) (
   input  logic        SRAM_sys_clk,
   input  logic        SRAM_rst_n,
   input  logic [17:0] SRAM_A,
   input  logic [15:0] SRAM_DB_I,
   output logic [15:0] SRAM_DB_O,
   output logic        SRAM_DB_T,
   input  logic        SRAM_CE_N,
   input  logic        SRAM_WE_N,
   input  logic        SRAM_OE_N,
   input  logic        SRAM_UB_N,
   input  logic        SRAM_LB_N,
   output logic [31:0] wr_count,
   output logic [31:0] rd_count,
   output logic        bus_conflict
`ifdef SRAM_RSP_FAULT_EN
   ,
   input  logic        fault_en,
   input  logic [17:0] fault_addr
`endif
);

   localparam int DEPTH = 1 << ADDR_W;

   logic        r_ce_n_s, r_we_n_s, r_oe_n_s, r_ub_n_s, r_lb_n_s;
   logic [17:0] r_a_s;
   logic [17:0] r_prev_a_s;
   logic [15:0] r_db_s;
   logic        r_prev_rd_s;
   logic [15:0] r_mem [DEPTH];
   logic [RD_LAT-1:0] r_vld_p;
   logic [15:0] r_dat_p [RD_LAT];
   logic [31:0] r_wr_cnt, r_rd_cnt;
   logic        r_conflict;

   logic        w_wr_s, w_rd_s, w_conf_s, w_lane_s, w_new_rd_s, w_fault_hit;
   logic [15:0] w_mem_q, w_rdata;
   logic [RD_LAT-1:0] w_vin;
   logic [15:0] w_din [RD_LAT];

   // Sample stage: control fields reset to an idle bus, data fields free-running
   always_ff @(posedge SRAM_sys_clk or negedge SRAM_rst_n) begin
      if (!SRAM_rst_n) begin
         r_ce_n_s    <= 1'b1;
         r_we_n_s    <= 1'b1;
         r_oe_n_s    <= 1'b1;
         r_ub_n_s    <= 1'b1;
         r_lb_n_s    <= 1'b1;
         r_prev_rd_s <= 1'b0;
      end else begin
         r_ce_n_s    <= SRAM_CE_N;
         r_we_n_s    <= SRAM_WE_N;
         r_oe_n_s    <= SRAM_OE_N;
         r_ub_n_s    <= SRAM_UB_N;
         r_lb_n_s    <= SRAM_LB_N;
         r_prev_rd_s <= w_rd_s;
      end
   end

   always_ff @(posedge SRAM_sys_clk) begin
      r_a_s      <= SRAM_A;
      r_db_s     <= SRAM_DB_I;
      r_prev_a_s <= r_a_s;
   end

   // A WE_N/OE_N clash decodes as a write so the pad never drives against the initiator
   assign w_wr_s     = ~r_ce_n_s & ~r_we_n_s;
   assign w_rd_s     = ~r_ce_n_s &  r_we_n_s & ~r_oe_n_s;
   assign w_conf_s   = ~r_we_n_s & ~r_oe_n_s;
   assign w_lane_s   = ~r_ub_n_s | ~r_lb_n_s;
   assign w_new_rd_s = w_rd_s & (~r_prev_rd_s | (r_prev_a_s != r_a_s));

`ifdef SRAM_RSP_FAULT_EN
   logic w_unused_fa;
   assign w_unused_fa = &{1'b0, fault_addr[17:ADDR_W]};
   assign w_fault_hit = fault_en & (r_a_s[ADDR_W-1:0] == fault_addr[ADDR_W-1:0]);
`else
   assign w_fault_hit = 1'b0;
`endif

   assign w_mem_q = r_mem[r_a_s[ADDR_W-1:0]] ^ {15'd0, w_fault_hit};
   assign w_rdata = {r_ub_n_s ? 8'h00 : w_mem_q[15:8], r_lb_n_s ? 8'h00 : w_mem_q[7:0]};

   always_ff @(posedge SRAM_sys_clk) begin
      if (w_wr_s && !r_ub_n_s) r_mem[r_a_s[ADDR_W-1:0]][15:8] <= r_db_s[15:8];
      if (w_wr_s && !r_lb_n_s) r_mem[r_a_s[ADDR_W-1:0]][7:0]  <= r_db_s[7:0];
   end

   // Read pipeline: stage 0 loads from the sample stage, last stage drives the pad
   for (genvar g = 0; g < RD_LAT; g++) begin : g_stg
      if (g == 0) begin : g_first
         assign w_vin[g] = w_rd_s;
         assign w_din[g] = w_rdata;
      end else begin : g_next
         assign w_vin[g] = r_vld_p[g-1];
         assign w_din[g] = r_dat_p[g-1];
      end
   end

   // A sampled write squashes every read still in flight
   always_ff @(posedge SRAM_sys_clk or negedge SRAM_rst_n) begin
      if (!SRAM_rst_n) begin
         r_vld_p <= '0;
         for (int i = 0; i < RD_LAT; i++) r_dat_p[i] <= 16'h0000;
      end else begin
         for (int i = 0; i < RD_LAT; i++) begin
            r_vld_p[i] <= w_vin[i] & ~w_wr_s;
            if (w_vin[i] && !w_wr_s) r_dat_p[i] <= w_din[i];
         end
      end
   end

   always_ff @(posedge SRAM_sys_clk or negedge SRAM_rst_n) begin
      if (!SRAM_rst_n) begin
         r_wr_cnt   <= 32'd0;
         r_rd_cnt   <= 32'd0;
         r_conflict <= 1'b0;
      end else begin
         if (w_wr_s && w_lane_s && (r_wr_cnt != 32'hFFFF_FFFF)) r_wr_cnt <= r_wr_cnt + 32'd1;
         if (w_new_rd_s && (r_rd_cnt != 32'hFFFF_FFFF)) r_rd_cnt <= r_rd_cnt + 32'd1;
         if (w_conf_s) r_conflict <= 1'b1;
      end
   end

   assign SRAM_DB_O    = r_dat_p[RD_LAT-1];
   assign SRAM_DB_T    = ~r_vld_p[RD_LAT-1] | w_wr_s;
   assign wr_count     = r_wr_cnt;
   assign rd_count     = r_rd_cnt;
   assign bus_conflict = r_conflict;

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder (RD_LAT=2, ADDR_W=10); fault case only when SRAM_RSP_FAULT_EN is set.
module tb_sram_responder;

   logic        clk, rst_n;
   logic [17:0] a;
   logic [15:0] dbi, dbo;
   logic        dbt, ce_n, we_n, oe_n, ub_n, lb_n, conf;
   logic [31:0] wrc, rdc;
   int          n_chk, n_fail;
`ifdef SRAM_RSP_FAULT_EN
   logic        f_en;
   logic [17:0] f_addr;
`endif

   sram_responder #(.ADDR_W(10), .RD_LAT(2)) dut (
      .SRAM_sys_clk(clk), .SRAM_rst_n(rst_n), .SRAM_A(a), .SRAM_DB_I(dbi),
      .SRAM_DB_O(dbo), .SRAM_DB_T(dbt), .SRAM_CE_N(ce_n), .SRAM_WE_N(we_n),
      .SRAM_OE_N(oe_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n),
      .wr_count(wrc), .rd_count(rdc), .bus_conflict(conf)
`ifdef SRAM_RSP_FAULT_EN
      , .fault_en(f_en), .fault_addr(f_addr)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change on the falling edge; each call spans exactly one rising edge
   task automatic drv(input logic ce, input logic we, input logic oe, input logic ub,
                      input logic lb, input logic [17:0] ad, input logic [15:0] d);
      ce_n = ce; we_n = we; oe_n = oe; ub_n = ub; lb_n = lb; a = ad; dbi = d;
      @(negedge clk);
   endtask

   task automatic wr(input logic [17:0] ad, input logic [15:0] d, input logic ub, input logic lb);
      drv(1'b0, 1'b0, 1'b1, ub, lb, ad, d);
   endtask

   task automatic rd(input logic [17:0] ad, input logic ub, input logic lb);
      drv(1'b0, 1'b1, 1'b0, ub, lb, ad, 16'h0000);
   endtask

   task automatic idle();
      drv(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 18'd0, 16'h0000);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1; ub_n = 1'b0; lb_n = 1'b0; a = '0; dbi = '0;
      @(negedge clk); @(negedge clk);
      n_chk++; if (dbt !== 1'b1)     begin n_fail++; $display("FAIL reset_dbt got %b exp 1", dbt); end
      n_chk++; if (dbo !== 16'h0000) begin n_fail++; $display("FAIL reset_dbo got %h exp 0000", dbo); end
      n_chk++; if (wrc !== 32'd0)    begin n_fail++; $display("FAIL reset_wrc got %0d exp 0", wrc); end
      n_chk++; if (rdc !== 32'd0)    begin n_fail++; $display("FAIL reset_rdc got %0d exp 0", rdc); end
      n_chk++; if (conf !== 1'b0)    begin n_fail++; $display("FAIL reset_conf got %b exp 0", conf); end
      rst_n = 1'b1;
      idle();
   endtask

   task automatic test_basic();
      wr(18'd0, 16'haa55, 1'b0, 1'b0);
      wr(18'd1, 16'h55aa, 1'b0, 1'b0);
      idle();
      rd(18'd0, 1'b0, 1'b0);
      n_chk++; if (dbt !== 1'b1) begin n_fail++; $display("FAIL basic_lat_early got %b exp 1", dbt); end
      rd(18'd1, 1'b0, 1'b0);
      idle();
      n_chk++; if (dbo !== 16'haa55 || dbt !== 1'b0) begin n_fail++; $display("FAIL basic_rd0 got %h/%b exp aa55/0", dbo, dbt); end
      idle();
      n_chk++; if (dbo !== 16'h55aa || dbt !== 1'b0) begin n_fail++; $display("FAIL basic_rd1 got %h/%b exp 55aa/0", dbo, dbt); end
      idle();
      n_chk++; if (dbo !== 16'h55aa || dbt !== 1'b1) begin n_fail++; $display("FAIL basic_hold got %h/%b exp 55aa/1", dbo, dbt); end
      n_chk++; if (wrc !== 32'd2) begin n_fail++; $display("FAIL basic_wrc got %0d exp 2", wrc); end
      n_chk++; if (rdc !== 32'd2) begin n_fail++; $display("FAIL basic_rdc got %0d exp 2", rdc); end
   endtask

   task automatic test_raw();
      wr(18'd2, 16'h1234, 1'b0, 1'b0);
      rd(18'd2, 1'b0, 1'b0);
      idle(); idle();
      n_chk++; if (dbo !== 16'h1234 || dbt !== 1'b0) begin n_fail++; $display("FAIL raw got %h/%b exp 1234/0", dbo, dbt); end
      idle();
   endtask

   task automatic test_byte_lanes();
      wr(18'd3, 16'hffff, 1'b0, 1'b0);
      wr(18'd3, 16'h1234, 1'b1, 1'b0);
      wr(18'd3, 16'h0000, 1'b1, 1'b1);
      idle();
      rd(18'd3, 1'b0, 1'b0);
      rd(18'd3, 1'b0, 1'b1);
      rd(18'd3, 1'b1, 1'b0);
      n_chk++; if (dbo !== 16'hff34) begin n_fail++; $display("FAIL lane_full got %h exp ff34", dbo); end
      idle();
      n_chk++; if (dbo !== 16'hff00) begin n_fail++; $display("FAIL lane_lb_off got %h exp ff00", dbo); end
      idle();
      n_chk++; if (dbo !== 16'h0034) begin n_fail++; $display("FAIL lane_ub_off got %h exp 0034", dbo); end
      idle();
      n_chk++; if (wrc !== 32'd5) begin n_fail++; $display("FAIL lane_wrc got %0d exp 5", wrc); end
      n_chk++; if (rdc !== 32'd4) begin n_fail++; $display("FAIL lane_rdc got %0d exp 4", rdc); end
   endtask

   task automatic test_alias();
      wr(18'h00407, 16'hbeef, 1'b0, 1'b0);
      idle();
      rd(18'd7, 1'b0, 1'b0);
      rd(18'h3fc07, 1'b0, 1'b0);
      idle();
      n_chk++; if (dbo !== 16'hbeef) begin n_fail++; $display("FAIL alias_lo got %h exp beef", dbo); end
      idle();
      n_chk++; if (dbo !== 16'hbeef || dbt !== 1'b0) begin n_fail++; $display("FAIL alias_hi got %h/%b exp beef/0", dbo, dbt); end
      idle();
      n_chk++; if (rdc !== 32'd6) begin n_fail++; $display("FAIL alias_rdc got %0d exp 6", rdc); end
   endtask

   task automatic test_read_to_write();
      rd(18'd0, 1'b0, 1'b0);
      wr(18'd9, 16'h1111, 1'b0, 1'b0);
      n_chk++; if (dbt !== 1'b1) begin n_fail++; $display("FAIL r2w_at_wr got %b exp 1", dbt); end
      idle();
      n_chk++; if (dbt !== 1'b1) begin n_fail++; $display("FAIL r2w_squash got %b exp 1", dbt); end
      idle();
      rd(18'd9, 1'b0, 1'b0);
      idle(); idle();
      n_chk++; if (dbo !== 16'h1111 || dbt !== 1'b0) begin n_fail++; $display("FAIL r2w_rd got %h/%b exp 1111/0", dbo, dbt); end
      idle();
      n_chk++; if (wrc !== 32'd7 || rdc !== 32'd8) begin n_fail++; $display("FAIL r2w_cnt got %0d/%0d exp 7/8", wrc, rdc); end
   endtask

   task automatic test_conflict();
      drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 18'd8, 16'h0f0f);
      n_chk++; if (dbt !== 1'b1) begin n_fail++; $display("FAIL conf_dbt got %b exp 1", dbt); end
      idle();
      n_chk++; if (conf !== 1'b1 || dbt !== 1'b1) begin n_fail++; $display("FAIL conf_set got %b/%b exp 1/1", conf, dbt); end
      idle(); idle();
      rd(18'd8, 1'b0, 1'b0);
      idle(); idle();
      n_chk++; if (dbo !== 16'h0f0f) begin n_fail++; $display("FAIL conf_wr_data got %h exp 0f0f", dbo); end
      idle();
      n_chk++; if (conf !== 1'b1) begin n_fail++; $display("FAIL conf_sticky got %b exp 1", conf); end
      n_chk++; if (wrc !== 32'd8 || rdc !== 32'd9) begin n_fail++; $display("FAIL conf_cnt got %0d/%0d exp 8/9", wrc, rdc); end
   endtask

   task automatic test_reset_mid_read();
      rd(18'd0, 1'b0, 1'b0);
      rd(18'd1, 1'b0, 1'b0);
      rd(18'd0, 1'b0, 1'b0);
      n_chk++; if (dbt !== 1'b0 || dbo !== 16'haa55) begin n_fail++; $display("FAIL mid_pre got %h/%b exp aa55/0", dbo, dbt); end
      #2 rst_n = 1'b0;
      #1;
      n_chk++; if (dbt !== 1'b1 || dbo !== 16'h0000) begin n_fail++; $display("FAIL mid_async got %h/%b exp 0000/1", dbo, dbt); end
      n_chk++; if (wrc !== 32'd0 || rdc !== 32'd0 || conf !== 1'b0) begin n_fail++; $display("FAIL mid_clear got %0d/%0d/%b exp 0/0/0", wrc, rdc, conf); end
      idle();
      rst_n = 1'b1;
      idle();
      rd(18'd1, 1'b0, 1'b0);
      idle(); idle();
      n_chk++; if (dbo !== 16'h55aa || dbt !== 1'b0) begin n_fail++; $display("FAIL mid_after got %h/%b exp 55aa/0", dbo, dbt); end
      idle();
      n_chk++; if (rdc !== 32'd1 || wrc !== 32'd0) begin n_fail++; $display("FAIL mid_cnt got %0d/%0d exp 1/0", rdc, wrc); end
   endtask

`ifdef SRAM_RSP_FAULT_EN
   task automatic test_fault();
      wr(18'd5, 16'haa55, 1'b0, 1'b0);
      wr(18'd6, 16'haa55, 1'b0, 1'b0);
      f_addr = 18'd5;
      f_en   = 1'b1;
      rd(18'd5, 1'b0, 1'b0);
      rd(18'd6, 1'b0, 1'b0);
      idle();
      n_chk++; if (dbo !== 16'haa54) begin n_fail++; $display("FAIL fault_hit got %h exp aa54", dbo); end
      idle();
      n_chk++; if (dbo !== 16'haa55) begin n_fail++; $display("FAIL fault_miss got %h exp aa55", dbo); end
      f_en = 1'b0;
      rd(18'd5, 1'b0, 1'b0);
      idle(); idle();
      n_chk++; if (dbo !== 16'haa55) begin n_fail++; $display("FAIL fault_stored got %h exp aa55", dbo); end
      idle();
   endtask
`endif

   initial begin
      n_chk = 0;
      n_fail = 0;
`ifdef SRAM_RSP_FAULT_EN
      f_en = 1'b0;
      f_addr = '0;
`endif
      test_reset();
      test_basic();
      test_raw();
      test_byte_lanes();
      test_alias();
      test_read_to_write();
      test_conflict();
      test_reset_mid_read();
`ifdef SRAM_RSP_FAULT_EN
      test_fault();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
